// File: rtl/i2c_mon_pkg.sv
// Shared types and constants for the passive I2C bus monitor.
package i2c_mon_pkg;

  localparam int   I2C_MON_REC_W = 11;
  localparam logic I2C_ACK       = 1'b0;
  localparam logic I2C_NACK      = 1'b1;

  typedef struct packed {
    logic [7:0] data;
    logic       ack;
    logic       is_addr;
    logic       restart;
  } i2c_mon_rec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2
  } i2c_mon_state_t;

endpackage

// File: rtl/i2c_mon_fifo.sv
// Synchronous record FIFO with occupancy count and sticky overflow flag.
module i2c_mon_fifo
  import i2c_mon_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  i2c_mon_rec_t               push_rec_i,
  input  logic                       pop_i,
  input  logic                       clear_ovf_i,
  output i2c_mon_rec_t               head_rec_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  i2c_mon_rec_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q;
  logic          do_pop_s, do_push_s, drop_s;

  // Push and pop qualification; a pop frees the slot a full-level push needs.
  always_comb begin
    do_pop_s  = pop_i && (count_q != '0);
    do_push_s = push_i && ((count_q != CNT_FULL) || do_pop_s);
    drop_s    = push_i && !do_push_s;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers, count and sticky overflow (set wins over clear).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_rec_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop_s) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      if (drop_s)           ovf_q <= 1'b1;
      else if (clear_ovf_i) ovf_q <= 1'b0;
      else                  ovf_q <= ovf_q;
    end
  end

  assign valid_o    = (count_q != '0);
  assign head_rec_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C observer: sync/filter SCL and SDA, detect START/STOP, assemble
// byte+ACK records and queue them for a valid/ready consumer.
module i2c_bus_monitor
  import i2c_mon_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          scl_i,
  input  logic                          sda_i,
  output logic                          rec_valid_o,
  input  logic                          rec_ready_i,
  output logic [7:0]                    rec_data_o,
  output logic                          rec_ack_o,
  output logic                          rec_is_addr_o,
  output logic                          rec_restart_o,
  output logic                          evt_start_o,
  output logic                          evt_stop_o,
  output logic                          bus_busy_o,
  output logic                          overflow_o,
  input  logic                          clear_ovf_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int FCW = $clog2(FILTER_LEN + 1);

  // Returns {filtered_next, count_next}: count runs while the sample disagrees.
  function automatic logic [FCW:0] filt_step(input logic s, input logic f,
                                             input logic [FCW-1:0] c);
    logic [FCW:0] r;
    if (s == f)                              r = {f, {FCW{1'b0}}};
    else if (c == FCW'(FILTER_LEN - 1))      r = {s, {FCW{1'b0}}};
    else                                     r = {f, c + FCW'(1)};
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic [FCW-1:0]         scl_cnt_q, sda_cnt_q;
  logic                   scl_f_q, sda_f_q, scl_p_q, sda_p_q;
  logic [FCW:0]           scl_step_s, sda_step_s;
  logic                   start_s, stop_s, scl_rise_s;

  i2c_mon_state_t state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           is_addr_q, is_addr_d, restart_q, restart_d;
  logic           busy_q, busy_d, evt_start_q, evt_start_d, evt_stop_q, evt_stop_d;
  logic           push_q, push_d;
  i2c_mon_rec_t   rec_q, rec_d, head_s;

  assign scl_step_s = filt_step(scl_sync_q[SYNC_STAGES-1], scl_f_q, scl_cnt_q);
  assign sda_step_s = filt_step(sda_sync_q[SYNC_STAGES-1], sda_f_q, sda_cnt_q);

  // A condition needs SCL stable high; an SCL rise in the same cycle is data.
  assign start_s    = scl_p_q && scl_f_q &&  sda_p_q && !sda_f_q;
  assign stop_s     = scl_p_q && scl_f_q && !sda_p_q &&  sda_f_q;
  assign scl_rise_s = !scl_p_q && scl_f_q;

  // Transfer FSM next-state; STOP outranks START, disable outranks both.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    is_addr_d   = is_addr_q;
    restart_d   = restart_q;
    busy_d      = busy_q;
    evt_start_d = 1'b0;
    evt_stop_d  = 1'b0;
    push_d      = 1'b0;
    rec_d       = rec_q;
    if (!enable_i) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else if (stop_s) begin
      evt_stop_d = 1'b1;
      busy_d     = 1'b0;
      state_d    = IDLE;
    end else if (start_s) begin
      evt_start_d = 1'b1;
      busy_d      = 1'b1;
      is_addr_d   = 1'b1;
      restart_d   = (state_q != IDLE);
      bit_cnt_d   = 3'd0;
      state_d     = SHIFT;
    end else if (scl_rise_s) begin
      case (state_q)
        SHIFT: begin
          shift_d   = {shift_q[6:0], sda_f_q};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = (bit_cnt_q == 3'd7) ? ACK : SHIFT;
        end
        ACK: begin
          push_d        = 1'b1;
          rec_d.data    = shift_q;
          rec_d.ack     = sda_f_q;
          rec_d.is_addr = is_addr_q;
          rec_d.restart = restart_q;
          is_addr_d     = 1'b0;
          restart_d     = 1'b0;
          bit_cnt_d     = 3'd0;
          state_d       = SHIFT;
        end
        default: state_d = state_q;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Line conditioning, edge history and FSM registers; idle bus is all ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_cnt_q   <= '0;
      sda_cnt_q   <= '0;
      scl_f_q     <= 1'b1;
      sda_f_q     <= 1'b1;
      scl_p_q     <= 1'b1;
      sda_p_q     <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      is_addr_q   <= 1'b0;
      restart_q   <= 1'b0;
      busy_q      <= 1'b0;
      evt_start_q <= 1'b0;
      evt_stop_q  <= 1'b0;
      push_q      <= 1'b0;
      rec_q       <= '0;
    end else begin
      scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      {scl_f_q, scl_cnt_q} <= scl_step_s;
      {sda_f_q, sda_cnt_q} <= sda_step_s;
      scl_p_q     <= scl_f_q;
      sda_p_q     <= sda_f_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      is_addr_q   <= is_addr_d;
      restart_q   <= restart_d;
      busy_q      <= busy_d;
      evt_start_q <= evt_start_d;
      evt_stop_q  <= evt_stop_d;
      push_q      <= push_d;
      rec_q       <= rec_d;
    end
  end

  i2c_mon_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_q),
    .push_rec_i  (rec_q),
    .pop_i       (rec_ready_i),
    .clear_ovf_i (clear_ovf_i),
    .head_rec_o  (head_s),
    .valid_o     (rec_valid_o),
    .count_o     (fifo_count_o),
    .overflow_o  (overflow_o)
  );

  assign rec_data_o    = head_s.data;
  assign rec_ack_o     = head_s.ack;
  assign rec_is_addr_o = head_s.is_addr;
  assign rec_restart_o = head_s.restart;
  assign evt_start_o   = evt_start_q;
  assign evt_stop_o    = evt_stop_q;
  assign bus_busy_o    = busy_q;

endmodule
